// File: rtl/fpnew_lane_packer_if.sv
// Handshake bundle between a serialised lane unit and the lane packer.
// slave: the packer side; master: the lane unit / downstream side.
interface fpnew_lane_packer_if #(
  parameter int unsigned FP_WIDTH = 32,
  parameter int unsigned WIDTH    = 64,
  parameter type         TagType  = logic
);

  logic [FP_WIDTH-1:0] lane_result_i;
  logic [4:0]          lane_status_i;
  logic                lane_ext_bit_i;
  TagType              lane_tag_i;
  logic                lane_vectorial_i;
  logic                lane_valid_i;
  logic                lane_ready_o;
  logic                flush_i;
  logic [WIDTH-1:0]    result_o;
  logic [4:0]          status_o;
  logic                extension_bit_o;
  TagType              tag_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic                busy_o;

  modport slave (
    input  lane_result_i, lane_status_i, lane_ext_bit_i, lane_tag_i,
    input  lane_vectorial_i, lane_valid_i, flush_i, out_ready_i,
    output lane_ready_o, result_o, status_o, extension_bit_o, tag_o,
    output out_valid_o, busy_o
  );

  modport master (
    output lane_result_i, lane_status_i, lane_ext_bit_i, lane_tag_i,
    output lane_vectorial_i, lane_valid_i, flush_i, out_ready_i,
    input  lane_ready_o, result_o, status_o, extension_bit_o, tag_o,
    input  out_valid_o, busy_o
  );

endinterface

// File: rtl/fpnew_lane_packer.sv
// Output-side lane assembler: rebuilds a packed Width-bit result from serial
// per-lane beats (lane 0 first) and ORs their status flags.

package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

endpackage

// state   | meaning
// IDLE    | nothing held, waiting for a lane-0 beat
// COLLECT | lane 0 taken, gathering lanes 1..NUM_LANES-1
// OUTPUT  | packed result presented, waiting for out_ready_i
module fpnew_lane_packer #(
  parameter fpnew_pkg::fp_format_e FpFormat        = fpnew_pkg::FP32,
  parameter int unsigned           Width           = 64,
  parameter logic                  EnableNanBoxing = 1'b1,
  parameter type                   TagType         = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fpnew_lane_packer_if.slave   io
);

  localparam int unsigned FP_WIDTH  = fpnew_pkg::fp_width(FpFormat);
  localparam int unsigned NUM_LANES = Width / FP_WIDTH;
  localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PACKED    = NUM_LANES * FP_WIDTH;
  // Ones over the lane area, zeros over the pad bits above the last lane.
  localparam logic [Width-1:0] LANE_MASK = {Width{1'b1}} >> (Width - PACKED);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LANE_BITS-1:0] cnt_q, cnt_d;
  logic [Width-1:0]     result_q, result_d;
  logic [4:0]           status_q, status_d;
  logic                 ext_q, ext_d;
  TagType               tag_q, tag_d;

  logic beat;
  logic take_first;
  logic first_fill;
  logic pad_fill;

  // Ready is held low during reset so no beat can sneak in as reset releases.
  assign io.lane_ready_o = ~rst_i & ((state_q != OUTPUT) | io.out_ready_i);
  assign beat            = io.lane_valid_i & io.lane_ready_o;

  assign first_fill = EnableNanBoxing & io.lane_ext_bit_i;
  assign pad_fill   = EnableNanBoxing & ext_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    status_d   = status_q;
    ext_d      = ext_q;
    tag_d      = tag_q;
    take_first = 1'b0;

    if (io.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: take_first = beat;

        COLLECT: begin
          if (beat) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              if (cnt_q == LANE_BITS'(i)) begin
                result_d[i*FP_WIDTH +: FP_WIDTH] = io.lane_result_i;
              end
            end
            status_d = status_q | io.lane_status_i;
            if (cnt_q == LAST_LANE) begin
              result_d = (result_d & LANE_MASK) | ({Width{pad_fill}} & ~LANE_MASK);
              cnt_d    = '0;
              state_d  = OUTPUT;
            end else begin
              cnt_d = cnt_q + LANE_BITS'(1);
            end
          end
        end

        OUTPUT: begin
          if (io.out_ready_i) begin
            state_d    = IDLE;
            take_first = beat;
          end
        end

        default: state_d = IDLE;
      endcase

      if (take_first) begin
        tag_d    = io.lane_tag_i;
        ext_d    = io.lane_ext_bit_i;
        status_d = io.lane_status_i;
        if (!io.lane_vectorial_i || (NUM_LANES == 1)) begin
          result_d                 = {Width{first_fill}};
          result_d[FP_WIDTH-1:0]   = io.lane_result_i;
          cnt_d                    = '0;
          state_d                  = OUTPUT;
        end else begin
          result_d[FP_WIDTH-1:0]   = io.lane_result_i;
          cnt_d                    = LANE_BITS'(1);
          state_d                  = COLLECT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      ext_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
      ext_q    <= ext_d;
      tag_q    <= tag_d;
    end
  end

  assign io.result_o        = result_q;
  assign io.status_o        = status_q;
  assign io.extension_bit_o = ext_q;
  assign io.tag_o           = tag_q;
  assign io.out_valid_o     = (state_q == OUTPUT);
  assign io.busy_o          = (state_q != IDLE);

endmodule
